// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic/shift/compare ops plus iterative
// unsigned multiply/divide writing HI/LO, with a start/busy/done handshake.
module multicycle_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH),
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic             Zero,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  typedef enum logic [3:0] {
    OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_LUI, OP_SLL, OP_SRL,
    OP_BEQ, OP_BNE, OP_SRA, OP_SLT, OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO
  } op_t;

  state_t           state, state_next;
  op_t              op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic             is_mult;
  logic             is_div;

  assign op      = op_t'(ALUOperation);
  assign is_mult = (op == OP_MULTU);
  assign is_div  = (op == OP_DIVU);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_LUI:  alu_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  alu_res = B << shamt;
      OP_SRL:  alu_res = B >> shamt;
      OP_BEQ:  alu_res = WIDTH'(A != B);
      OP_BNE:  alu_res = WIDTH'(A == B);
      OP_SRA:  alu_res = $signed(B) >>> shamt;
      OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
      OP_MFHI: alu_res = Hi;
      OP_MFLO: alu_res = Lo;
      default: alu_res = '0;
    endcase
  end

  // Shared accumulator pair: MUL keeps {partial product, multiplier}; DIV keeps
  // {remainder, dividend/quotient}, so completion writes Hi/Lo identically.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, op_a});
    div_diff  = div_shift[WIDTH-1:0] - op_a;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && is_mult)     state_next = MUL;
        else if (start && is_div) state_next = DIV;
      end
      MUL, DIV: if (count == '0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      Zero      <= 1'b1;
      ALUResult <= '0;
      Hi        <= '0;
      Lo        <= '0;
      count     <= '0;
      op_a      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mult || is_div) begin
              busy   <= 1'b1;
              count  <= CW'(WIDTH);
              op_a   <= is_mult ? A : B;
              acc_hi <= '0;
              acc_lo <= is_mult ? B : A;
            end else begin
              ALUResult <= alu_res;
              Zero      <= (alu_res == '0);
              done      <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          if (count != '0) begin
            count <= count - CW'(1);
            if (state == MUL) begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end else begin
              acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end
          end else begin
            Hi        <= acc_hi;
            Lo        <= acc_lo;
            ALUResult <= acc_lo;
            Zero      <= (acc_lo == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
Parametrised successor to the single-cycle datapath ALU. Keeps the existing logic/arithmetic/shift/branch-compare opcodes and adds SRA, SLT and iterative unsigned multiply/divide with HI/LO registers and MFHI/MFLO. A start/busy/done handshake lets the multicycle control FSM stall on MULTU/DIVU. All outputs are registered.

Parameters:
WIDTH, 32, datapath width in bits; even, >= 8.
SHW, $clog2(WIDTH), shamt width (derived; not overridden).
CW, $clog2(WIDTH+1), iteration counter width (derived).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  operation request; sampled only in IDLE.
ALUOperation  input  4  opcode, sampled with start.
A  input  WIDTH  operand A, sampled with start.
B  input  WIDTH  operand B, sampled with start.
shamt  input  SHW  shift amount, sampled with start.
busy  output  1  high while a MULTU/DIVU is in progress.
done  output  1  one-cycle pulse: ALUResult/Zero updated.
Zero  output  1  registered (ALUResult==0).
ALUResult  output  WIDTH  registered result.
Hi  output  WIDTH  HI register.
Lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, Zero=1, ALUResult=0, Hi=0, Lo=0, counter=0. Reset mid-MULTU/DIVU aborts the operation; no partial HI/LO write.
- Opcodes: 0 AND; 1 OR; 2 NOR; 3 ADD; 4 SUB (both wrap mod 2^WIDTH, no overflow flag); 5 LUI = {B[WIDTH/2-1:0], WIDTH/2 zeros}; 6 SLL = B<<shamt; 7 SRL = B>>shamt (zero fill); 8 BEQ result 0 if A==B else 1; 9 BNE result 1 if A==B else 0; A SRA = B>>>shamt (sign fill); B SLT = 1 if signed A < signed B else 0; C MULTU; D DIVU; E MFHI = Hi; F MFLO = Lo.
- States: IDLE, MUL, DIV.
- IDLE, start=1, single-cycle op (0-B, E, F): on that edge ALUResult <= result, Zero <= (result==0), done <= 1 for exactly one cycle. Latency 1. Back-to-back starts give done every cycle.
- IDLE, start=1, MULTU/DIVU: operands latched; busy<=1; counter<=WIDTH; go to MUL/DIV. done=0.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH product accumulator. DIV: restoring divide, one quotient bit per cycle. Counter decrements every cycle. After the cycle that brings the counter to 0, the next edge writes Hi/Lo (MUL: Hi=product[2W-1:W], Lo=product[W-1:0]; DIV: Lo=quotient, Hi=remainder), sets ALUResult<=new Lo, Zero<=(new Lo==0), done<=1, busy<=0, state IDLE. Total: done high in cycle start_edge+WIDTH+1.
- DIVU with B==0: runs the full WIDTH cycles; result Lo = all ones, Hi = A. No exception.
- start while busy: ignored; operands and opcode not re-sampled; no queuing.
- start=0 in IDLE: outputs hold; done=0.
- Hi/Lo change only on MULTU/DIVU completion. MFHI/MFLO issued on the cycle after done return the new values.
- ALUResult, Zero, Hi and Lo hold their values between operations.

Test Plan:
1. Reset asserted asynchronously mid-cycle -> immediately busy=0, done=0, ALUResult=0, Zero=1, Hi=Lo=0.
2. ADD A=0xFFFFFFFF B=1 -> next cycle done=1, ALUResult=0, Zero=1. SUB 5-7 -> 0xFFFFFFFE. SLT A=0xFFFFFFFF B=1 -> 1. SRA B=0x80000000 shamt=4 -> 0xF8000000. LUI B=0x1234 -> 0x12340000.
3. MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy for 32 cycles, done in cycle 33. Hi=0xFFFFFFFE, Lo=0x00000001. Then MFHI -> 0xFFFFFFFE.
4. DIVU A=100 B=7 -> Lo=14, Hi=2, ALUResult=14. DIVU A=9 B=0 -> Lo=0xFFFFFFFF, Hi=9.
5. start pulsed with ADD while DIVU busy -> ignored; only one done, which carries the DIVU result. Reset asserted at iteration 10 of MULTU -> Hi/Lo remain 0, next ADD works normally.
6. Back-to-back BEQ A=B=3 then BNE A=B=3 -> ALUResult 0 (Zero=1) then 1 (Zero=0), done high two consecutive cycles. Rerun with WIDTH=16: MULTU 0xFFFF*0xFFFF -> Hi=0xFFFE, Lo=0x0001, done in cycle 17.
